// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

  localparam int SUB_WIDTH_DEF = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle of serial_subtractor; the zero flag exists only under SERIAL_SUB_ZERO_FLAG_EN.
interface serial_subtractor_if
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic             zero;

  modport master (output start, a, b, input busy, done, diff, borrow_out, zero);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out, zero);
`else
  modport master (output start, a, b, input busy, done, diff, borrow_out);
  modport slave  (input start, a, b, output busy, done, diff, borrow_out);
`endif

endinterface

// File: rtl/half_subtractor.sv
// Combinational half subtractor: d = x - y, bo set when y > x.
module half_subtractor (
  input  logic x,
  input  logic y,
  output logic d,
  output logic bo
);

  assign d  = x ^ y;
  assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first; start-to-done latency WIDTH+1 edges, optional zero flag via SERIAL_SUB_ZERO_FLAG_EN.
// No backpressure: start is ignored while busy, results are held until the next done.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SUB_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  sub_state_t state, state_nxt;

  logic             load;
  logic             step;
  logic             finish;
  logic             last;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-2:0] res_sr;
  logic             bin;

  logic             d0, bo0, d, bo1, bout;
  logic [WIDTH-1:0] res_nxt;

  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;

  // Full-subtractor cell: two half subtractors, borrows ORed.
  half_subtractor u_hs0 (.x(a_sr[0]), .y(b_sr[0]), .d(d0), .bo(bo0));
  half_subtractor u_hs1 (.x(d0),      .y(bin),     .d(d),  .bo(bo1));

  assign bout    = bo0 | bo1;
  assign res_nxt = {d, res_sr};
  assign last    = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last)      state_nxt = DONE;
      DONE:    state_nxt = bus.start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    load   = 1'b0;
    step   = 1'b0;
    finish = 1'b0;
    case (state)
      IDLE:    load = bus.start;
      RUN: begin
        step   = 1'b1;
        finish = last;
      end
      DONE:    load = bus.start;
      default: load = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      bin    <= 1'b0;
    end else if (load) begin
      cnt    <= '0;
      a_sr   <= bus.a;
      b_sr   <= bus.b;
      res_sr <= '0;
      bin    <= 1'b0;
    end else if (step) begin
      cnt    <= cnt + 1'b1;
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_nxt[WIDTH-1:1];
      bin    <= bout;
    end
  end

  // Status flags follow the next state so they come straight from flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
      if (finish) begin
        diff_q   <= res_nxt;
        borrow_q <= bout;
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk) begin
    if (rst)         zero_q <= 1'b0;
    else if (finish) zero_q <= ~|res_nxt;
  end

  assign bus.zero = zero_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 8); zero-flag checks only under SERIAL_SUB_ZERO_FLAG_EN.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(8)) bus ();

  serial_subtractor #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operation from start to done, then a quiet window that must hold no further done.
  // pulse_at >= 0 re-asserts start with 0xFF/0xFF after that many RUN edges.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       input logic [7:0] ed, input logic eb,
                       input int pulse_at, input string tag);
    int k;
    int busy_n;
    int overlap;
    int extra;
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    tick();
    bus.a   = ~av;
    bus.b   = ~bv;
    k       = 0;
    busy_n  = 0;
    overlap = 0;
    while (!bus.done && k < 20) begin
      if (bus.busy) busy_n++;
      if (k == pulse_at) begin
        bus.start = 1'b1;
        bus.a     = 8'hFF;
        bus.b     = 8'hFF;
      end else begin
        bus.start = 1'b0;
      end
      tick();
      k++;
    end
    bus.start = 1'b0;
    check({tag, "_done"},    32'(bus.done), 32'd1);
    check({tag, "_latency"}, 32'(k + 1), 32'd9);
    check({tag, "_busy_n"},  32'(busy_n), 32'd8);
    check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, "_diff"},    32'(bus.diff), 32'(ed));
    check({tag, "_borrow"},  32'(bus.borrow_out), 32'(eb));
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) extra++;
      if (bus.busy && bus.done) overlap++;
    end
    check({tag, "_no_extra_done"}, 32'(extra), 32'd0);
    check({tag, "_no_busy_done_overlap"}, 32'(overlap), 32'd0);
    check({tag, "_diff_held"}, 32'(bus.diff), 32'(ed));
  endtask

  initial begin
    int k;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;

    // Reset, with start asserted: reset must win.
    bus.start = 1'b1;
    bus.a     = 8'h33;
    bus.b     = 8'h11;
    tick();
    tick();
    bus.start = 1'b0;
    check("rst_busy",   32'(bus.busy), 32'd0);
    check("rst_done",   32'(bus.done), 32'd0);
    check("rst_diff",   32'(bus.diff), 32'd0);
    check("rst_borrow", 32'(bus.borrow_out), 32'd0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check("rst_zero",   32'(bus.zero), 32'd0);
`endif
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(bus.busy), 32'd0);

    do_op(8'h5A, 8'h23, 8'h37, 1'b0, -1, "basic");
    do_op(8'h10, 8'h20, 8'hF0, 1'b1, -1, "under1");
    do_op(8'h00, 8'h01, 8'hFF, 1'b1, -1, "under2");
    do_op(8'hA5, 8'hA5, 8'h00, 1'b0, -1, "zero_res");
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check("zero_res_flag", 32'(bus.zero), 32'd1);
`endif
    do_op(8'h02, 8'h01, 8'h01, 1'b0, -1, "nonzero");
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check("nonzero_flag", 32'(bus.zero), 32'd0);
`endif
    do_op(8'h80, 8'h01, 8'h7F, 1'b0, 3, "start_ignored");

    // Back-to-back with start held high.
    bus.start = 1'b1;
    bus.a     = 8'h09;
    bus.b     = 8'h04;
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus.done && k < 30);
    check("b2b_first_latency", 32'(k), 32'd9);
    check("b2b_first_diff",    32'(bus.diff), 32'h05);
    check("b2b_first_borrow",  32'(bus.borrow_out), 32'd0);
    bus.a = 8'h04;
    bus.b = 8'h09;
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus.done && k < 30);
    bus.start = 1'b0;
    check("b2b_spacing",        32'(k), 32'd9);
    check("b2b_second_diff",    32'(bus.diff), 32'hFB);
    check("b2b_second_borrow",  32'(bus.borrow_out), 32'd1);
    tick();
    check("b2b_done_one_cycle", 32'(bus.done), 32'd0);
    check("b2b_idle_after",     32'(bus.busy), 32'd0);
    tick();

    // Reset on the 4th RUN edge abandons the operation.
    bus.start = 1'b1;
    bus.a     = 8'h55;
    bus.b     = 8'h11;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy",   32'(bus.busy), 32'd0);
    check("midrst_done",   32'(bus.done), 32'd0);
    check("midrst_diff",   32'(bus.diff), 32'd0);
    check("midrst_borrow", 32'(bus.borrow_out), 32'd0);
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    check("midrst_zero",   32'(bus.zero), 32'd0);
`endif
    k = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done || bus.busy) k++;
    end
    check("midrst_quiet", 32'(k), 32'd0);
    do_op(8'h03, 8'h01, 8'h02, 1'b0, -1, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial subtractor computing `a - b` over WIDTH cycles, LSB first. It uses one full-subtractor cell built from two half subtractors and a borrow flip-flop. It is the inverse-operation companion to the team's half-adder cell and sits behind the Tiny Tapeout top-level pin wrapper. Operands load in parallel on a `start` pulse; the result is presented in parallel with a one-cycle `done` pulse.

## Interface
- `WIDTH`, default 8: operand and result width. Legal range is ≥2.
- `clk`  input  1  : clock; all state updates on the rising edge.
- `rst`  input  1  : reset, synchronous and active-high.
- `start`  input  1  : request a subtraction. Sampled only in IDLE or DONE.
- `a`  input  WIDTH  : minuend. Captured on the accepting edge.
- `b`  input  WIDTH  : subtrahend. Captured on the accepting edge.
- `busy`  output  1  : high while in RUN.
- `done`  output  1  : one-cycle pulse; result valid.
- `diff`  output  WIDTH  : `(a - b) mod 2^WIDTH`. Held until the next `done`.
- `borrow_out`  output  1  : 1 when `a < b` (unsigned). Held with `diff`.
- `zero`  output  1  : only with `SERIAL_SUB_ZERO_FLAG_EN`; 1 when `diff == 0`. Held with `diff`.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - `start` = 1: latch `a` and `b` into shift registers, clear the borrow flop, set bit counter to 0, go to RUN.
  - Otherwise stay in IDLE.
- **RUN:** each cycle computes one bit from the operand register LSBs and the borrow flop `bin`:
  - `d = a0 ^ b0 ^ bin`
  - `bout = (~a0 & b0) | (~(a0 ^ b0) & bin)`
  - `d` shifts into the MSB of the result register; both operand registers shift right; `bout` loads the borrow flop; the counter increments.
  - When the counter reaches WIDTH-1, `diff`, `borrow_out` and `zero` are registered from the completed values and the block goes to DONE.
- **DONE:** lasts one cycle, `done` = 1.
  - `start` = 1: accepted exactly as in IDLE, going straight to RUN (back-to-back operation).
  - Otherwise go to IDLE.
- `start` is ignored in RUN. No queuing, and latched operands are unaffected.
- `a` and `b` may change freely after the accepting edge.
- All arithmetic is unsigned modulo 2^WIDTH. `borrow_out` is the final borrow.
- **Reset values:** state IDLE, `busy` 0, `done` 0, `diff` 0, `borrow_out` 0, `zero` 0. The counter, operand registers and borrow flop are also 0.
- **Reset mid-RUN or in DONE:** the operation is abandoned, all outputs take their reset values on that edge, and no `done` is produced.
- **Reset together with `start`:** reset wins and the request is dropped.

## Timing
- Let edge E0 be the edge that accepts `start`.
- `busy` is high for exactly WIDTH cycles, from after E0 until E(WIDTH).
- Bits are processed on edges E1 through E(WIDTH).
- At E(WIDTH), `done` rises, `busy` falls, and `diff`/`borrow_out`/`zero` update.
- `done` is high for exactly one cycle.
- Start-to-done latency is WIDTH+1 edges.
- **Back-to-back throughput:** with `start` held high, one result every WIDTH+1 cycles.
- `busy` and `done` are never high together.
- All outputs come straight from flops; there are no combinational paths from input to output.

## Configuration
- **Macro:** `SERIAL_SUB_ZERO_FLAG_EN`.
- **Defined:**
  - The `zero` port exists.
  - `zero` is registered at E(WIDTH) as the NOR of the final result bits.
  - `zero` holds until the next `done` and resets to 0.
- **Undefined:**
  - The `zero` port and its logic are absent.
  - All other behaviour and timing are identical.

## Structure
- **Shared package `serial_sub_pkg`:**
  - State enum `sub_state_t` {IDLE, RUN, DONE}.
  - Default width constant `SUB_WIDTH_DEF = 8`.
- **Sub-module `half_subtractor`:** purely combinational, inputs x and y, outputs `d = x ^ y` and `bo = ~x & y`.
  - Two instances form the full-subtractor cell.
  - Borrow out is the OR of the two instances' borrow outputs.
- **Top `serial_subtractor`:** contains the FSM, counter of width `$clog2(WIDTH)`, operand and result shift registers, borrow flop and output registers.

## Test plan
(WIDTH = 8 throughout.)
- **Basic subtraction:** `a` = 0x5A, `b` = 0x23, `start` pulse → after 9 edges, `done` = 1 for one cycle, `diff` = 0x37, `borrow_out` = 0, `busy` high for exactly 8 cycles.
- **Underflow:**
  - `a` = 0x10, `b` = 0x20 → `diff` = 0xF0, `borrow_out` = 1.
  - `a` = 0x00, `b` = 0x01 → `diff` = 0xFF, `borrow_out` = 1.
- **Zero result, with `SERIAL_SUB_ZERO_FLAG_EN`:** `a` = 0xA5, `b` = 0xA5 → `diff` = 0x00, `borrow_out` = 0, `zero` = 1. A following 0x02 − 0x01 → `zero` = 0, `diff` = 0x01.
- **Start ignored while busy:** 0x80 − 0x01 started, then `start` is pulsed at cycle 3 with `a` = 0xFF, `b` = 0xFF → a single `done`, `diff` = 0x7F. No second result appears.
- **Back-to-back:** `start` held high with `a`/`b` = 0x09/0x04, then switched to 0x04/0x09 when `done` is high → `done` pulses 9 cycles apart. Results are 0x05 (`borrow_out` 0), then 0xFB (`borrow_out` 1).
- **Reset mid-operation:** `rst` = 1 on the 4th RUN edge → all outputs are 0 on that edge, no `done` follows, and the next `start` with 0x03 − 0x01 gives `diff` = 0x02 normally.
